// File: rtl/lsu_wb_ctrl_pkg.sv
// Shared encodings for the MEM/WB controller: op classes, access sizes, FSM states.
package lsu_wb_ctrl_pkg;

  localparam int unsigned StateWidth = 3;

  localparam logic [StateWidth-1:0] OP_IDLE               = 3'd0;
  localparam logic [StateWidth-1:0] OP_REG_WRITE          = 3'd1;
  localparam logic [StateWidth-1:0] OP_MEM_READ_REG_WRITE = 3'd2;
  localparam logic [StateWidth-1:0] OP_MEM_WRITE          = 3'd3;
  localparam logic [StateWidth-1:0] OP_PC_SELECT_WRITE    = 3'd4;
  localparam logic [StateWidth-1:0] OP_PC_WRITE           = 3'd5;
  localparam logic [StateWidth-1:0] OP_LUI_REG_WRITE      = 3'd6;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Encodings with no matching instruction on this datapath width are rejected like misalignment.
  function automatic logic func3_legal(input logic [2:0] f3, input logic is_store,
                                       input int unsigned data_w);
    logic ok;
    ok = 1'b1;
    if (f3[1:0] == SZ_D && data_w < 64) ok = 1'b0;
    if (f3[2] && (is_store || f3[1:0] == SZ_D || (f3[1:0] == SZ_W && data_w < 64))) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_wb_ctrl_lane_align.sv
// Byte-lane steering: store replicate + strobe generation, load lane extract + sign/zero extend.
module lsu_lane_align #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]                        i_st_func3,
  input  logic [$clog2(DATA_W/8)-1:0]       i_st_off,
  input  logic [DATA_W-1:0]                 i_st_data,
  output logic [DATA_W-1:0]                 o_st_wdata,
  output logic [DATA_W/8-1:0]               o_st_wstrb,
  input  logic [2:0]                        i_ld_func3,
  input  logic [$clog2(DATA_W/8)-1:0]       i_ld_off,
  input  logic [DATA_W-1:0]                 i_ld_rdata,
  output logic [DATA_W-1:0]                 o_ld_data
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  logic [3:0]        w_st_nb;
  logic [DATA_W-1:0] w_ld_shift;
  logic [6:0]        w_ld_bits;
  logic              w_ld_sign;

  assign w_st_nb    = 4'd1 << i_st_func3[1:0];
  assign w_ld_shift = i_ld_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_st_wdata = '0;
    o_st_wstrb = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      o_st_wdata[i*8 +: 8] = i_st_data[(i & 32'(w_st_nb - 4'd1))*8 +: 8];
      o_st_wstrb[i] = (i >= 32'(i_st_off)) && (i < 32'(i_st_off) + 32'(w_st_nb));
    end
  end

  // Extend from the access width; clamp keeps the sign-bit index inside the word.
  always_comb begin
    o_ld_data = '0;
    w_ld_bits = 7'd8 << i_ld_func3[1:0];
    if (32'(w_ld_bits) > DATA_W) w_ld_bits = 7'(DATA_W);
    w_ld_sign = ~i_ld_func3[2] & w_ld_shift[w_ld_bits - 7'd1];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      o_ld_data[i] = (i < 32'(w_ld_bits)) ? w_ld_shift[i] : w_ld_sign;
    end
  end

  logic [OFF_W-1:0] w_unused_off;
  assign w_unused_off = i_st_off ^ i_ld_off;

endmodule

// File: rtl/lsu_wb_ctrl.sv
// MEM/WB-stage controller: one op per handshake, wait-state data port, registered writeback/redirect.
module lsu_wb_ctrl
  import lsu_wb_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [StateWidth-1:0] state,
  input  logic [2:0]            func3,
  input  logic [DATA_W-1:0]     alu_o,
  input  logic [DATA_W-1:0]     imm,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [ADDR_W-1:0]     pc_base,
  input  logic [ADDR_W-1:0]     pc_link,
  output logic                  stall,
  output logic                  reg_write_enable,
  output logic [DATA_W-1:0]     reg_write_data,
  output logic                  pc_write_enable,
  output logic [ADDR_W-1:0]     pc_write_data,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        r_state,     w_state_nxt;
  logic              r_in_ready,  r_stall;
  logic              r_rwe,       w_rwe_nxt;
  logic [DATA_W-1:0] r_rwd,       w_rwd_nxt;
  logic              r_pwe,       w_pwe_nxt;
  logic [ADDR_W-1:0] r_pwd,       w_pwd_nxt;
  logic [DATA_W-1:0] r_fwd,       w_fwd_nxt;
  logic              r_misalign,  w_misalign_nxt;
  logic              r_bus_err,   w_bus_err_nxt;
  logic              r_mem_req,   w_mem_req_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [NB-1:0]     r_mem_wstrb, w_mem_wstrb_nxt;
  logic [CNT_W-1:0]  r_wait_cnt,  w_wait_cnt_nxt;
  logic [2:0]        r_ld_func3,  w_ld_func3_nxt;
  logic [OFF_W-1:0]  r_ld_off,    w_ld_off_nxt;
  logic [DATA_W-1:0] r_st_data,   w_st_data_nxt;

  logic [OFF_W-1:0]  w_off, w_size_mask;
  logic              w_is_store, w_bad_access;
  logic [DATA_W-1:0] w_st_wdata, w_ld_data;
  logic [NB-1:0]     w_st_wstrb;

  assign w_off        = alu_o[OFF_W-1:0];
  assign w_is_store   = (state == OP_MEM_WRITE);
  assign w_size_mask  = OFF_W'((4'd1 << func3[1:0]) - 4'd1);
  assign w_bad_access = (|(w_off & w_size_mask)) | ~func3_legal(func3, w_is_store, DATA_W);

  lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .i_st_func3 (func3),
    .i_st_off   (w_off),
    .i_st_data  (store_data),
    .o_st_wdata (w_st_wdata),
    .o_st_wstrb (w_st_wstrb),
    .i_ld_func3 (r_ld_func3),
    .i_ld_off   (r_ld_off),
    .i_ld_rdata (mem_rdata),
    .o_ld_data  (w_ld_data)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_rwe_nxt       = 1'b0;
    w_rwd_nxt       = r_rwd;
    w_pwe_nxt       = 1'b0;
    w_pwd_nxt       = r_pwd;
    w_fwd_nxt       = r_fwd;
    w_misalign_nxt  = 1'b0;
    w_bus_err_nxt   = 1'b0;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_ld_func3_nxt  = r_ld_func3;
    w_ld_off_nxt    = r_ld_off;
    w_st_data_nxt   = r_st_data;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          case (state)
            OP_REG_WRITE: begin
              w_rwe_nxt = 1'b1; w_rwd_nxt = alu_o; w_fwd_nxt = alu_o; w_state_nxt = S_DONE;
            end
            OP_LUI_REG_WRITE: begin
              w_rwe_nxt = 1'b1; w_rwd_nxt = imm; w_fwd_nxt = imm; w_state_nxt = S_DONE;
            end
            OP_PC_WRITE: begin
              w_pwe_nxt = 1'b1; w_pwd_nxt = ADDR_W'(alu_o);
              w_rwe_nxt = 1'b1; w_rwd_nxt = DATA_W'(pc_link); w_fwd_nxt = DATA_W'(pc_link);
              w_state_nxt = S_DONE;
            end
            OP_PC_SELECT_WRITE: begin
              if (alu_o[0]) begin
                w_pwe_nxt = 1'b1; w_pwd_nxt = pc_base + ADDR_W'(imm);
              end
              w_state_nxt = S_DONE;
            end
            OP_MEM_READ_REG_WRITE, OP_MEM_WRITE: begin
              if (w_bad_access) begin
                w_misalign_nxt = 1'b1;
              end else begin
                w_mem_req_nxt   = 1'b1;
                w_mem_we_nxt    = w_is_store;
                w_mem_addr_nxt  = ADDR_W'(alu_o) & ~ADDR_W'(NB - 1);
                w_mem_wdata_nxt = w_st_wdata;
                w_mem_wstrb_nxt = w_is_store ? w_st_wstrb : '0;
                w_wait_cnt_nxt  = '0;
                w_ld_func3_nxt  = func3;
                w_ld_off_nxt    = w_off;
                w_st_data_nxt   = store_data;
                w_state_nxt     = S_BUSY;
              end
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_wstrb_nxt = '0;
          w_state_nxt     = S_DONE;
          if (r_mem_we) begin
            w_fwd_nxt = r_st_data;
          end else begin
            w_rwe_nxt = 1'b1; w_rwd_nxt = w_ld_data; w_fwd_nxt = w_ld_data;
          end
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_wstrb_nxt = '0;
          w_bus_err_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_stall     <= 1'b0;
      r_rwe       <= 1'b0;
      r_rwd       <= '0;
      r_pwe       <= 1'b0;
      r_pwd       <= '0;
      r_fwd       <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_wait_cnt  <= '0;
      r_ld_func3  <= '0;
      r_ld_off    <= '0;
      r_st_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_stall     <= (w_state_nxt != S_IDLE);
      r_rwe       <= w_rwe_nxt;
      r_rwd       <= w_rwd_nxt;
      r_pwe       <= w_pwe_nxt;
      r_pwd       <= w_pwd_nxt;
      r_fwd       <= w_fwd_nxt;
      r_misalign  <= w_misalign_nxt;
      r_bus_err   <= w_bus_err_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_ld_func3  <= w_ld_func3_nxt;
      r_ld_off    <= w_ld_off_nxt;
      r_st_data   <= w_st_data_nxt;
    end
  end

  assign in_ready         = r_in_ready;
  assign stall            = r_stall;
  assign reg_write_enable = r_rwe;
  assign reg_write_data   = r_rwd;
  assign pc_write_enable  = r_pwe;
  assign pc_write_data    = r_pwd;
  assign fwd_data         = r_fwd;
  assign misalign         = r_misalign;
  assign bus_err          = r_bus_err;
  assign mem_req          = r_mem_req;
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign mem_wstrb        = r_mem_wstrb;

endmodule

// File: tb/tb_lsu_wb_ctrl.sv
// Directed bench for lsu_wb_ctrl with a writeback/redirect scoreboard.
module tb_lsu_wb_ctrl;
  import lsu_wb_ctrl_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, mem_ack = 1'b0;
  logic [2:0]  state = 3'd0, func3 = 3'd0;
  logic [31:0] alu_o = '0, imm = '0, store_data = '0, pc_base = '0, pc_link = '0, mem_rdata = '0;
  logic        in_ready, stall, reg_write_enable, pc_write_enable, misalign, bus_err, mem_req, mem_we;
  logic [31:0] reg_write_data, pc_write_data, fwd_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0, n_err = 0, n_stall = 0, n_req = 0;
  logic [31:0] rd_q[$], pc_q[$];
  logic [31:0] wd;
  logic        seen;

  lsu_wb_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .state(state),
    .func3(func3), .alu_o(alu_o), .imm(imm), .store_data(store_data), .pc_base(pc_base),
    .pc_link(pc_link), .stall(stall), .reg_write_enable(reg_write_enable),
    .reg_write_data(reg_write_data), .pc_write_enable(pc_write_enable),
    .pc_write_data(pc_write_data), .fwd_data(fwd_data), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; pulses seen here are checked against the scoreboard queues.
  task automatic tick();
    @(posedge clk); #1;
    if (stall) n_stall++;
    if (reg_write_enable) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 64'(reg_write_enable), 64'd0);
      else chk("rd_data", 64'(reg_write_data), 64'(rd_q.pop_front()));
    end
    if (pc_write_enable) begin
      if (pc_q.size() == 0) chk("pc_unexpected", 64'(pc_write_enable), 64'd0);
      else chk("pc_data", 64'(pc_write_data), 64'(pc_q.pop_front()));
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] im, input logic [31:0] sd, input logic [31:0] pb,
                       input logic [31:0] pl);
    state = op; func3 = f3; alu_o = a; imm = im; store_data = sd; pc_base = pb; pc_link = pl;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input int waits, input logic [31:0] exp);
    rd_q.push_back(exp);
    issue(OP_MEM_READ_REG_WRITE, f3, a, '0, '0, '0, '0);
    chk({tag, "_req"}, 64'(mem_req), 64'd1);
    chk({tag, "_addr"}, 64'(mem_addr), 64'(a & 32'hFFFF_FFFC));
    chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'd0);
    repeat (waits) tick();
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_fwd"}, 64'(fwd_data), 64'(exp));
    chk({tag, "_drain"}, 64'(rd_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tick(); tick();
    chk("rst_rwe", 64'(reg_write_enable), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_fwd", 64'(fwd_data), 64'd0);
    reset = 1'b1;
    tick();
    chk("rst_ready", 64'(in_ready), 64'd1);

    // LW with wait states: 3 busy cycles + 1 done cycle of stall
    n_stall = 0;
    do_load("lw", 3'd2, 32'h104, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    chk("lw_stall", 64'(n_stall), 64'd4);
    chk("lw_ready", 64'(in_ready), 64'd1);

    do_load("lb",  3'd0, 32'h103, 32'h8011_2233, 0, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 32'h103, 32'h8011_2233, 1, 32'h0000_0080);
    do_load("lh",  3'd1, 32'h102, 32'h8011_2233, 0, 32'hFFFF_8011);
    do_load("lhu", 3'd5, 32'h100, 32'h8011_A233, 0, 32'h0000_A233);

    // SB into lane 1
    issue(OP_MEM_WRITE, 3'd0, 32'h201, '0, 32'h0000_00AB, '0, '0);
    wd = mem_wdata;
    chk("sb_req", 64'(mem_req), 64'd1);
    chk("sb_we", 64'(mem_we), 64'd1);
    chk("sb_addr", 64'(mem_addr), 64'h200);
    chk("sb_wstrb", 64'(mem_wstrb), 64'b0010);
    chk("sb_lane", 64'(wd[15:8]), 64'hAB);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("sb_fwd", 64'(fwd_data), 64'hAB);
    chk("sb_reqdrop", 64'(mem_req), 64'd0);
    tick();

    issue(OP_MEM_WRITE, 3'd1, 32'h202, '0, 32'h5555_1234, '0, '0);
    chk("sh_wstrb", 64'(mem_wstrb), 64'b1100);
    chk("sh_wdata", 64'(mem_wdata), 64'h1234_1234);
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("sh_fwd", 64'(fwd_data), 64'h5555_1234);
    tick();

    // Misaligned SW, then an op accepted on the very next cycle
    issue(OP_MEM_WRITE, 3'd2, 32'h102, '0, 32'h99, '0, '0);
    chk("sw_mis", 64'(misalign), 64'd1);
    chk("sw_noreq", 64'(mem_req), 64'd0);
    chk("sw_ready", 64'(in_ready), 64'd1);
    rd_q.push_back(32'h55);
    issue(OP_REG_WRITE, 3'd0, 32'h55, '0, '0, '0, '0);
    chk("rw_mis_clr", 64'(misalign), 64'd0);
    chk("rw_fwd", 64'(fwd_data), 64'h55);
    tick();

    rd_q.push_back(32'h1234_5000);
    issue(OP_LUI_REG_WRITE, 3'd0, 32'h0, 32'h1234_5000, '0, '0, '0);
    chk("lui_fwd", 64'(fwd_data), 64'h1234_5000);
    tick();

    // Taken branch wraps around the address space
    pc_q.push_back(32'h0000_0010);
    issue(OP_PC_SELECT_WRITE, 3'd0, 32'h1, 32'h20, '0, 32'hFFFF_FFF0, '0);
    chk("br_pwe", 64'(pc_write_enable), 64'd1);
    tick();

    issue(OP_PC_SELECT_WRITE, 3'd0, 32'h0, 32'h20, '0, 32'h100, '0);
    chk("brnt_pwe", 64'(pc_write_enable), 64'd0);
    chk("brnt_rwe", 64'(reg_write_enable), 64'd0);
    chk("brnt_busy", 64'(in_ready), 64'd0);
    tick();
    chk("brnt_ready", 64'(in_ready), 64'd1);

    issue(OP_MEM_READ_REG_WRITE, 3'd3, 32'h100, '0, '0, '0, '0);
    chk("ld32_mis", 64'(misalign), 64'd1);
    chk("ld32_noreq", 64'(mem_req), 64'd0);
    tick();

    // LW never acknowledged
    issue(OP_MEM_READ_REG_WRITE, 3'd2, 32'h300, '0, '0, '0, '0);
    n_req = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mem_req) n_req++;
      if (bus_err) seen = 1'b1;
      else tick();
    end
    chk("to_buserr", 64'(bus_err), 64'd1);
    chk("to_cycles", 64'(n_req), 64'd15);
    chk("to_reqlow", 64'(mem_req), 64'd0);
    chk("to_ready", 64'(in_ready), 64'd1);
    tick();
    chk("to_pulse", 64'(bus_err), 64'd0);

    // Reset while busy, then a late ack must be ignored
    issue(OP_MEM_READ_REG_WRITE, 3'd2, 32'h400, '0, '0, '0, '0);
    tick();
    reset = 1'b0;
    tick();
    chk("rb_req", 64'(mem_req), 64'd0);
    chk("rb_fwd", 64'(fwd_data), 64'd0);
    chk("rb_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("rb_late_ack", 64'(reg_write_enable), 64'd0);
    chk("rb_fwd_hold", 64'(fwd_data), 64'd0);

    rd_q.push_back(32'h18);
    pc_q.push_back(32'h400);
    issue(OP_PC_WRITE, 3'd0, 32'h400, '0, '0, 32'h14, 32'h18);
    chk("jal_rwe", 64'(reg_write_enable), 64'd1);
    chk("jal_pwe", 64'(pc_write_enable), 64'd1);
    chk("jal_fwd", 64'(fwd_data), 64'h18);
    tick();
    tick();
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    chk("pc_q_empty", 64'(pc_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
